// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one single-CS SPI master between two requesters.
// The granted transaction goes to the master one byte at a time; the MISO bytes come back to the owner as one word.
//
// state   | meaning
// IDLE    | no transaction; grant a request, latch count/data/owner
// SEND    | wait for TX_Ready, then issue one TX_DV for byte k
// WAIT_RX | wait for the master's RX_DV for byte k
// DONE    | Done pulse cycle for the owner
// GAP     | wait for the master to go idle (CS released) before the next grant

module spi_txn_arbiter #(
    parameter int MAX_BYTES = 2,
    parameter int CNT_W     = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_Req_0,
    input  logic                   i_Req_1,
    input  logic [CNT_W-1:0]       i_Count_0,
    input  logic [CNT_W-1:0]       i_Count_1,
    input  logic [8*MAX_BYTES-1:0] i_Data_0,
    input  logic [8*MAX_BYTES-1:0] i_Data_1,
    output logic                   o_Done_0,
    output logic                   o_Done_1,
    output logic                   o_Err_0,
    output logic                   o_Err_1,
    output logic [8*MAX_BYTES-1:0] o_RX_Data_0,
    output logic [8*MAX_BYTES-1:0] o_RX_Data_1,
    output logic                   o_Busy,
    output logic                   o_Owner,
    output logic [CNT_W-1:0]       o_TX_Count,
    output logic [7:0]             o_TX_Byte,
    output logic                   o_TX_DV,
    input  logic                   i_TX_Ready,
    input  logic                   i_RX_DV,
    input  logic [7:0]             i_RX_Byte
);

    localparam int DW = 8 * MAX_BYTES;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RX,
        S_DONE,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic             any_req, grant_sel, rr_ptr_q, owner_q;
    logic [CNT_W-1:0] req_cnt, cnt_clamp, cnt_q, k_q;
    logic [DW-1:0]    req_data, data_aligned, tx_sr_q, rx_sr_q, rx_next;
    logic [TW-1:0]    tmr_q;
    logic             tmo, last_byte;
    logic             fin_set, fin_err, fin_owner;
    logic [DW-1:0]    fin_data;

    assign o_Owner = owner_q;

    // rr_ptr_q names the requester that wins a tie; after reset that is requester 0.
    always_comb begin
        any_req      = i_Req_0 | i_Req_1;
        grant_sel    = (i_Req_0 & i_Req_1) ? rr_ptr_q : i_Req_1;
        req_cnt      = grant_sel ? i_Count_1 : i_Count_0;
        req_data     = grant_sel ? i_Data_1 : i_Data_0;
        cnt_clamp    = (int'(req_cnt) > MAX_BYTES) ? CNT_W'(MAX_BYTES) : req_cnt;
        data_aligned = req_data << (8 * (MAX_BYTES - int'(cnt_clamp)));
        rx_next      = (rx_sr_q << 8) | DW'(i_RX_Byte);
        last_byte    = (CNT_W'(k_q + 1'b1) == cnt_q);
        tmo          = (tmr_q == '0) && (state_q inside {S_SEND, S_WAIT_RX, S_GAP});
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // fin_* describes a completion (normal or aborted) that is reported on the next cycle.
    always_comb begin
        state_d   = state_q;
        fin_set   = 1'b0;
        fin_err   = 1'b0;
        fin_owner = owner_q;
        fin_data  = rx_sr_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    if (cnt_clamp == '0) begin
                        state_d   = S_DONE;
                        fin_set   = 1'b1;
                        fin_owner = grant_sel;
                        fin_data  = '0;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (i_TX_Ready) begin
                    state_d = S_WAIT_RX;
                end else if (tmo) begin
                    state_d = S_IDLE;
                    fin_set = 1'b1;
                    fin_err = 1'b1;
                end
            end
            S_WAIT_RX: begin
                if (i_RX_DV) begin
                    if (last_byte) begin
                        state_d  = S_DONE;
                        fin_set  = 1'b1;
                        fin_data = rx_next;
                    end else begin
                        state_d = S_SEND;
                    end
                end else if (tmo) begin
                    state_d = S_IDLE;
                    fin_set = 1'b1;
                    fin_err = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                if (i_TX_Ready) begin
                    state_d = S_IDLE;
                end else if (tmo) begin
                    state_d = S_IDLE;
                    fin_set = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Down-counter reloaded on every state change; terminal count 0 means TIMEOUT cycles spent in the state.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tmr_q <= TW'(TIMEOUT - 1);
        end else if (state_d != state_q) begin
            tmr_q <= TW'(TIMEOUT - 1);
        end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rr_ptr_q    <= 1'b0;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            k_q         <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            o_Busy      <= 1'b0;
            o_TX_DV     <= 1'b0;
            o_TX_Byte   <= '0;
            o_TX_Count  <= '0;
            o_Done_0    <= 1'b0;
            o_Done_1    <= 1'b0;
            o_Err_0     <= 1'b0;
            o_Err_1     <= 1'b0;
            o_RX_Data_0 <= '0;
            o_RX_Data_1 <= '0;
        end else begin
            o_TX_DV  <= 1'b0;
            o_Done_0 <= fin_set & ~fin_owner;
            o_Done_1 <= fin_set & fin_owner;
            o_Err_0  <= fin_set & fin_err & ~fin_owner;
            o_Err_1  <= fin_set & fin_err & fin_owner;
            if (fin_set && !fin_owner) begin
                o_RX_Data_0 <= fin_data;
            end
            if (fin_set && fin_owner) begin
                o_RX_Data_1 <= fin_data;
            end
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        owner_q  <= grant_sel;
                        rr_ptr_q <= ~grant_sel;
                        cnt_q    <= cnt_clamp;
                        tx_sr_q  <= data_aligned;
                        k_q      <= '0;
                        rx_sr_q  <= '0;
                        o_Busy   <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (i_TX_Ready) begin
                        o_TX_DV    <= 1'b1;
                        o_TX_Byte  <= tx_sr_q[DW-1 -: 8];
                        tx_sr_q    <= tx_sr_q << 8;
                        o_TX_Count <= cnt_q;
                    end
                end
                S_WAIT_RX: begin
                    if (i_RX_DV) begin
                        rx_sr_q <= rx_next;
                        k_q     <= k_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if ((fin_set && fin_err) || (state_q == S_GAP && i_TX_Ready)) begin
                o_Busy <= 1'b0;
            end
        end
    end

endmodule
